// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: data width, canonical NOP,
// fetch FSM encoding and PC increment.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch FSM plus IF/ID pipeline register with stall, redirect/flush
// and a one-entry hold buffer. `FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cycles
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            kill_q, kill_d;
  logic            drop_q, drop_d, drop_on_rst;
  logic [XLEN-1:0] hold_inst_q, hold_inst_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;

  logic            rsp_live;
  logic            id_free;
  logic            load_en;
  logic [XLEN-1:0] load_inst;
  logic [XLEN-1:0] load_pc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    drop_d        = drop_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    load_en       = 1'b0;
    load_inst     = imem_rsp_data;
    load_pc       = inflight_pc_q;

    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;

    // drop_q marks a response still owed for a request that a reset abandoned
    rsp_live = imem_rsp_valid && !drop_q;
    if (imem_rsp_valid && drop_q) drop_d = 1'b0;
    drop_on_rst = imem_rsp_valid ? (drop_q && state_q == S_WAIT)
                                 : (drop_q || state_q == S_WAIT);

    id_free = !id_valid_q || !id_stall;
    if (id_valid_q && !id_stall) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end

    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          inflight_pc_d = pc_q;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_live) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (id_free) begin
            load_en = 1'b1;
            pc_d    = inflight_pc_q + PC_STEP;
            state_d = S_REQ;
          end else begin
            hold_inst_d = imem_rsp_data;
            hold_pc_d   = inflight_pc_q;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!id_stall) begin
          load_en   = 1'b1;
          load_inst = hold_inst_q;
          load_pc   = hold_pc_q;
          pc_d      = hold_pc_q + PC_STEP;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (load_en) begin
      id_valid_d    = 1'b1;
      id_inst_d     = load_inst;
      id_pc_d       = load_pc;
      id_pc_plus4_d = load_pc + PC_STEP;
    end

    // A response landing in the redirect cycle is the one being killed, so
    // no kill needs to be carried forward in that case.
    if (redirect_valid) begin
      load_en    = 1'b0;
      pc_d       = redirect_pc & ~32'h0000_0003;
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      if ((state_q == S_WAIT && !rsp_live) ||
          (state_q == S_REQ && imem_req_ready)) begin
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      drop_q        <= drop_on_rst;
      hold_inst_q   <= '0;
      hold_pc_q     <= '0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= '0;
      id_pc_plus4_q <= PC_STEP;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      drop_q        <= drop_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (load_en && perf_fetched_q != '1) perf_fetched_d = perf_fetched_q + 32'd1;
    if (id_valid_q && id_stall && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural instruction memory pushes
// expected {pc, word} on each accepted request; tasks pop and compare.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        id_stall       = 1'b0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } mem_rsp_t;

  exp_t        sb[$];
  mem_rsp_t    mq[$];
  int unsigned mem_lat = 1;
  int unsigned cyc     = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0093;
      32'h0000_0004: return 32'h0010_8113;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Memory model: decides handshakes at the negedge for the following posedge.
  initial forever begin
    @(negedge clk);
    cyc++;
    imem_rsp_valid = 1'b0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
      void'(mq.pop_front());
    end
    if (!rst && imem_req_valid && imem_req_ready) begin
      mq.push_back('{due: cyc + mem_lat, data: mem_word(imem_req_addr)});
      sb.push_back('{pc: imem_req_addr, inst: mem_word(imem_req_addr)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_id_valid got %0h want 0", id_valid); end
    tests_run++; if (id_inst !== 32'h13) begin tests_failed++; $display("FAIL rst_id_inst got %h want 00000013", id_inst); end
    tests_run++; if (id_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_id_pc got %h want 0", id_pc); end
    tests_run++; if (id_pc_plus4 !== 32'h4) begin tests_failed++; $display("FAIL rst_id_pc_plus4 got %h want 4", id_pc_plus4); end
    tests_run++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL rst_req got v=%0b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int unsigned nreq = 0, got = 0;
    exp_t e;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (imem_req_valid && nreq < 2) begin
        tests_run++; if (imem_req_addr !== 32'(nreq * 4)) begin tests_failed++; $display("FAIL basic_req_addr got %h want %h", imem_req_addr, 32'(nreq * 4)); end
        nreq++;
      end
      if (id_valid) begin
        if (sb.size() == 0) begin tests_run++; tests_failed++; $display("FAIL basic_sb_empty got id_pc %h want none", id_pc); end
        else begin
          e = sb.pop_front();
          tests_run++; if ({id_inst, id_pc, id_pc_plus4} !== {e.inst, e.pc, e.pc + 32'd4}) begin tests_failed++; $display("FAIL basic_id got %h/%h/%h want %h/%h/%h", id_inst, id_pc, id_pc_plus4, e.inst, e.pc, e.pc + 32'd4); end
        end
        got++;
        if (got == 2) imem_req_ready = 1'b0;
      end
      if (got < 2) tick();
    end
    tests_run++; if (got != 2) begin tests_failed++; $display("FAIL basic_timeout got %0d words want 2", got); end
    tick();
  endtask

  task automatic test_stall();
    int unsigned got = 0;
    exp_t e;
    logic [96:0] snap;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    for (int c = 0; c < 20 && got == 0; c++) begin
      tick();
      if (id_valid) got = 1;
    end
    tests_run++; if (got == 0) begin tests_failed++; $display("FAIL stall_first_timeout got none want word"); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests_run++; if (id_pc !== e.pc) begin tests_failed++; $display("FAIL stall_first_pc got %h want %h", id_pc, e.pc); end
    end
    id_stall = 1'b1;
    snap = {id_valid, id_inst, id_pc};
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests_run++; if ({id_valid, id_inst, id_pc} !== snap) begin tests_failed++; $display("FAIL stall_hold_%0d got %h want %h", k, {id_valid, id_inst, id_pc}, snap); end
      if (k >= 2) begin
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_no_req_%0d got %0b want 0", k, imem_req_valid); end
      end
    end
    tests_run++; if (dut.state_q !== S_HOLD) begin tests_failed++; $display("FAIL stall_state got %0d want %0d", dut.state_q, S_HOLD); end
    tests_run++; if (sb.size() != 1) begin tests_failed++; $display("FAIL stall_outstanding got %0d want 1", sb.size()); end
    id_stall = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    tests_run++; if (id_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_release_valid got %0b want 1", id_valid); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests_run++; if ({id_inst, id_pc, id_pc_plus4} !== {e.inst, e.pc, e.pc + 32'd4}) begin tests_failed++; $display("FAIL stall_release_id got %h/%h/%h want %h/%h/%h", id_inst, id_pc, id_pc_plus4, e.inst, e.pc, e.pc + 32'd4); end
    end
    tick();
  endtask

  task automatic test_redirect_wait();
    int unsigned nreq = 0, got = 0;
    exp_t e;
    mem_lat = 3;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    tests_run++; if ({id_valid, id_inst} !== {1'b0, 32'h13}) begin tests_failed++; $display("FAIL rdw_flush got %0b/%h want 0/00000013", id_valid, id_inst); end
    for (int c = 0; c < 40 && got == 0; c++) begin
      if (imem_req_valid && nreq == 0) begin
        tests_run++; if (imem_req_addr !== 32'h100) begin tests_failed++; $display("FAIL rdw_req_addr got %h want 00000100", imem_req_addr); end
        nreq++;
      end
      if (id_valid) begin
        got = 1;
        imem_req_ready = 1'b0;
        if (sb.size() == 0) begin tests_run++; tests_failed++; $display("FAIL rdw_sb_empty got id_pc %h want none", id_pc); end
        else begin
          e = sb.pop_front();
          tests_run++; if ({id_inst, id_pc} !== {e.inst, 32'h100}) begin tests_failed++; $display("FAIL rdw_id got %h/%h want %h/00000100", id_inst, id_pc, e.inst); end
        end
      end
      if (got == 0) tick();
    end
    tests_run++; if (got == 0) begin tests_failed++; $display("FAIL rdw_timeout got none want word"); end
    tick();
  endtask

  task automatic test_redirect_req_stall();
    int unsigned nreq = 0, got = 0;
    exp_t e;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    for (int c = 0; c < 20 && got == 0; c++) begin
      tick();
      if (id_valid) got = 1;
    end
    tests_run++; if (got == 0) begin tests_failed++; $display("FAIL rrs_setup_timeout got none want word"); end
    id_stall       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    sb.delete();
    tests_run++; if ({id_valid, id_inst} !== {1'b0, 32'h13}) begin tests_failed++; $display("FAIL rrs_flush got %0b/%h want 0/00000013", id_valid, id_inst); end
    got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      if (imem_req_valid && nreq == 0) begin
        tests_run++; if (imem_req_addr !== 32'h200) begin tests_failed++; $display("FAIL rrs_req_addr got %h want 00000200", imem_req_addr); end
        nreq++;
      end
      if (id_valid) begin
        got = 1;
        imem_req_ready = 1'b0;
        if (sb.size() == 0) begin tests_run++; tests_failed++; $display("FAIL rrs_sb_empty got id_pc %h want none", id_pc); end
        else begin
          e = sb.pop_front();
          tests_run++; if ({id_inst, id_pc} !== {e.inst, 32'h200}) begin tests_failed++; $display("FAIL rrs_id got %h/%h want %h/00000200", id_inst, id_pc, e.inst); end
        end
      end
      if (got == 0) tick();
    end
    tests_run++; if (got == 0) begin tests_failed++; $display("FAIL rrs_timeout got none want word"); end
    tick();
  endtask

  task automatic test_reset_wait();
    int unsigned nreq = 0, got = 0;
    exp_t e;
    mem_lat = 3;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    tests_run++; if ({id_valid, id_inst, id_pc, id_pc_plus4} !== {1'b0, 32'h13, 32'h0, 32'h4}) begin tests_failed++; $display("FAIL rstw_id got %0b/%h/%h/%h want 0/00000013/0/4", id_valid, id_inst, id_pc, id_pc_plus4); end
    tests_run++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL rstw_req got %0b/%h want 1/0", imem_req_valid, imem_req_addr); end
    rst = 1'b0;
    sb.delete();
    imem_req_ready = 1'b1;
    for (int c = 0; c < 40 && got == 0; c++) begin
      if (imem_req_valid && nreq == 0) begin
        tests_run++; if (imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL rstw_req_addr got %h want 0", imem_req_addr); end
        nreq++;
      end
      if (id_valid) begin
        got = 1;
        imem_req_ready = 1'b0;
        if (sb.size() == 0) begin tests_run++; tests_failed++; $display("FAIL rstw_sb_empty got id_pc %h want none", id_pc); end
        else begin
          e = sb.pop_front();
          tests_run++; if ({id_inst, id_pc} !== {e.inst, e.pc}) begin tests_failed++; $display("FAIL rstw_id got %h/%h want %h/%h", id_inst, id_pc, e.inst, e.pc); end
        end
      end
      if (got == 0) tick();
    end
    tests_run++; if (got == 0) begin tests_failed++; $display("FAIL rstw_timeout got none want word"); end
    tick();
  endtask

  task automatic test_wrap();
    int unsigned nreq = 0, got = 0;
    exp_t e;
    logic [31:0] want_addr [2];
    want_addr[0] = 32'hFFFF_FFFC;
    want_addr[1] = 32'h0000_0000;
    mem_lat = 1;
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    imem_req_ready = 1'b1;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (imem_req_valid && nreq < 2) begin
        tests_run++; if (imem_req_addr !== want_addr[nreq]) begin tests_failed++; $display("FAIL wrap_req_addr%0d got %h want %h", nreq, imem_req_addr, want_addr[nreq]); end
        nreq++;
      end
      if (id_valid) begin
        if (sb.size() == 0) begin tests_run++; tests_failed++; $display("FAIL wrap_sb_empty got id_pc %h want none", id_pc); end
        else begin
          e = sb.pop_front();
          tests_run++; if ({id_inst, id_pc, id_pc_plus4} !== {e.inst, want_addr[got], want_addr[got] + 32'd4}) begin tests_failed++; $display("FAIL wrap_id%0d got %h/%h/%h want %h/%h/%h", got, id_inst, id_pc, id_pc_plus4, e.inst, want_addr[got], want_addr[got] + 32'd4); end
        end
        got++;
        if (got == 2) imem_req_ready = 1'b0;
      end
      if (got < 2) tick();
    end
    tests_run++; if (got != 2) begin tests_failed++; $display("FAIL wrap_timeout got %0d words want 2", got); end
`ifdef FETCH_PERF_CNT_EN
    tests_run++; if (perf_fetched !== 32'd2) begin tests_failed++; $display("FAIL perf_fetched got %0d want 2", perf_fetched); end
    tests_run++; if (perf_stall_cycles !== 32'd0) begin tests_failed++; $display("FAIL perf_stall got %0d want 0", perf_stall_cycles); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_req_stall();
    test_reset_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
